lc3_alu_sequencer: RTL

//  Operate-instruction execute controller for the LC-3 core. Accepts one ADD/AND/NOT instruction per handshake.

---
 rtl/lc3_pkg.sv | 45 ++++
 rtl/alu.sv | 28 ++
 rtl/lc3_regfile.sv | 42 ++++
 rtl/lc3_alu_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// ============================================================================
// lc3_pkg : opcodes, ALU select/state enums and condition-code helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package lc3_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    localparam logic [2:0] CC_N = 3'b100;
    localparam logic [2:0] CC_Z = 3'b010;
    localparam logic [2:0] CC_P = 3'b001;

    typedef enum logic [1:0] {
        SEL_NOT = 2'b00,
        SEL_AND = 2'b01,
        SEL_ADD = 2'b10
    } alu_sel_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_READ = 2'b01,
        S_EXEC = 2'b10,
        S_WB   = 2'b11
    } seq_state_t;

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return CC_N;
        else if (v == 16'h0000)
            return CC_Z;
        else
            return CC_P;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// alu : shared LC-3 datapath ALU (00 NOT a, 01 a AND b, 10 a + b)
// Rev 1.0
// ============================================================================
`default_nettype none

module alu #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] o
);

    always_comb begin
        o = a;
        case (sel)
            2'b00:   o = ~a;
            2'b01:   o = a & b;
            2'b10:   o = a + b;
            default: o = a;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lc3_regfile.sv
// ============================================================================
// lc3_regfile : 8x16 register file, two operand reads, debug read, one write
// Rev 1.0
// ============================================================================
`default_nettype none

module lc3_regfile #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    rd1_addr_i,
    output logic [WIDTH-1:0] rd1_data_o,
    input  logic [AW-1:0]    rd2_addr_i,
    output logic [WIDTH-1:0] rd2_data_o,
    input  logic [AW-1:0]    dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rd1_data_o = mem_q[rd1_addr_i];
    assign rd2_data_o = mem_q[rd2_addr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

`default_nettype wire

// File: rtl/lc3_alu_sequencer.sv
// ============================================================================
// lc3_alu_sequencer : LC-3 ADD/AND/NOT execute controller (IDLE-READ-EXEC-WB)
// Rev 1.0
// ============================================================================
`default_nettype none

module lc3_alu_sequencer
    import lc3_pkg::*;
#(
    parameter int         WIDTH    = 16,
    parameter int         NREGS    = 8,
    parameter logic [2:0] CC_RESET = 3'b010
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [15:0]      instr_i,
    output logic             done_o,
    output logic             err_o,
    output logic [2:0]       cc_o,
    input  logic [2:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    seq_state_t       state_q, state_d;
    alu_sel_t         sel_q, sel_d;
    logic [15:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             err_q, err_d;
    logic [2:0]       cc_q, cc_d;

    logic [WIDTH-1:0] rd1_data, rd2_data, alu_o;
    logic [1:0]       alu_sel;
    logic             rf_we;

    lc3_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (3)
    ) u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd1_addr_i (ir_q[8:6]),
        .rd1_data_o (rd1_data),
        .rd2_addr_i (ir_q[2:0]),
        .rd2_data_o (rd2_data),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .we_i       (rf_we),
        .waddr_i    (ir_q[11:9]),
        .wdata_i    (res_q)
    );

    alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .sel (alu_sel),
        .o   (alu_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sel_q   <= SEL_NOT;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cc_q    <= CC_RESET;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cc_q    <= cc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        ir_d          = ir_q;
        a_d           = a_q;
        b_d           = b_q;
        res_d         = res_q;
        err_d         = err_q;
        cc_d          = cc_q;
        alu_sel       = SEL_NOT;
        rf_we         = 1'b0;
        done_o        = 1'b0;
        instr_ready_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    ir_d    = instr_i;
                    err_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d = rd1_data;
                b_d = ir_q[5] ? sext5(ir_q[4:0]) : rd2_data;
                case (ir_q[15:12])
                    OP_ADD:  sel_d = SEL_ADD;
                    OP_AND:  sel_d = SEL_AND;
                    OP_NOT:  sel_d = SEL_NOT;
                    default: begin
                        sel_d = SEL_NOT;
                        err_d = 1'b1;
                    end
                endcase
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Rejected opcodes still pass through EXEC so done timing is uniform.
                if (!err_q) begin
                    alu_sel = sel_q;
                    res_d   = alu_o;
                end
                state_d = S_WB;
            end
            S_WB: begin
                done_o = 1'b1;
                if (!err_q) begin
                    rf_we = 1'b1;
                    cc_d  = cc_of(res_q);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_o = err_q;
    assign cc_o  = cc_q;

endmodule

`default_nettype wire
